// File: rtl/block_emitter.sv
// Streams the ASCII words "begin " / "end " one character per handshake while tracking nesting depth.
// Optional auto-close (emit "end " until depth reaches zero) is built only with BLOCK_EMITTER_AUTO_CLOSE_EN.
module block_emitter #(
  parameter int DEPTH_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  input  logic               cmd_op,
  output logic               cmd_ready,
  input  logic               flush,
  output logic               out_valid,
  output logic [7:0]         out_char,
  input  logic               out_ready,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic               balanced
);

  typedef enum logic [1:0] {IDLE, WORD, SEP} state_t;

  localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  state_t             state, state_nxt;
  logic               op, op_nxt;
  logic [2:0]         idx, idx_nxt;
  logic [DEPTH_W-1:0] depth_nxt;
  logic               err_nxt;
  logic               auto_start;
  logic               start;
  logic               start_op;
  logic               last;

  function automatic logic [7:0] begin_char(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h62;
      3'd1:    return 8'h65;
      3'd2:    return 8'h67;
      3'd3:    return 8'h69;
      3'd4:    return 8'h6E;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] end_char(input logic [2:0] i);
    case (i)
      3'd0:    return 8'h65;
      3'd1:    return 8'h6E;
      3'd2:    return 8'h64;
      default: return 8'h00;
    endcase
  endfunction

`ifdef BLOCK_EMITTER_AUTO_CLOSE_EN
  logic flushing, flushing_nxt;

  // Once started, a flush keeps issuing internal "end" words even if the flush input drops.
  assign auto_start = (state == IDLE) && (depth != '0) && (flushing || flush);

  always_comb begin
    flushing_nxt = flushing;
    if (auto_start)
      flushing_nxt = 1'b1;
    else if (state == IDLE)
      flushing_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) flushing <= 1'b0;
    else       flushing <= flushing_nxt;
  end
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign auto_start   = 1'b0;
`endif

  assign cmd_ready = (state == IDLE) && !auto_start;
  assign start     = auto_start || (cmd_valid && cmd_ready);
  assign start_op  = auto_start ? 1'b1 : cmd_op;
  assign last      = op ? (idx == 3'd2) : (idx == 3'd4);

  assign out_valid = (state != IDLE);
  assign balanced  = (depth == '0) && !err;

  always_comb begin
    out_char = 8'h00;
    case (state)
      WORD:    out_char = op ? end_char(idx) : begin_char(idx);
      SEP:     out_char = 8'h20;
      default: out_char = 8'h00;
    endcase
  end

  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    idx_nxt   = idx;
    depth_nxt = depth;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (start) begin
          op_nxt    = start_op;
          idx_nxt   = 3'd0;
          state_nxt = WORD;
          // Out-of-range commands are still emitted; only the counter saturates and err latches.
          if (!start_op) begin
            if (depth == DEPTH_MAX) err_nxt = 1'b1;
            else                    depth_nxt = depth + DEPTH_ONE;
          end else begin
            if (depth == '0) err_nxt = 1'b1;
            else             depth_nxt = depth - DEPTH_ONE;
          end
        end
      end
      WORD: begin
        if (out_ready) begin
          if (last) state_nxt = SEP;
          else      idx_nxt   = idx + 3'd1;
        end
      end
      SEP: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op    <= 1'b0;
      idx   <= 3'd0;
      depth <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      op    <= op_nxt;
      idx   <= idx_nxt;
      depth <= depth_nxt;
      err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_block_emitter.sv
// Randomized self-checking bench for block_emitter; expected words and depth/err come from a string/counter model.
module tb_block_emitter;
  localparam int DW   = 3;
  localparam int DMAX = (1 << DW) - 1;

  typedef logic [7:0] ch_q[$];

  logic          clk = 1'b0;
  logic          reset, cmd_valid, cmd_op, cmd_ready, flush;
  logic          out_valid, out_ready, err, balanced;
  logic [7:0]    out_char;
  logic [DW-1:0] depth;

  int n_cmp = 0;
  int n_bad = 0;
  int m_depth;
  bit m_err;

  always #5 clk = ~clk;

  block_emitter #(.DEPTH_W(DW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
    .flush(flush), .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
    .depth(depth), .err(err), .balanced(balanced)
  );

  function automatic string word_of(input bit op);
    return op ? "end " : "begin ";
  endfunction

  function automatic string hexs(input ch_q q);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  function automatic string hexw(input string w);
    string s = "";
    for (int i = 0; i < w.len(); i++) s = {s, $sformatf("%02h ", w[i])};
    return s;
  endfunction

  // Reference: begin opens a block (saturating), end closes one (floored); either misuse latches err.
  function automatic void model_cmd(input bit op);
    if (!op) begin
      if (m_depth == DMAX) m_err = 1'b1;
      else m_depth++;
    end else begin
      if (m_depth == 0) m_err = 1'b1;
      else m_depth--;
    end
  endfunction

  task automatic apply_reset;
    @(negedge clk);
    reset = 1'b1; cmd_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    m_depth = 0; m_err = 1'b0;
  endtask

  // Issues one command from a negedge and collects every transferred character.
  // mode 0: out_ready high; 1: pattern 1,0,0 repeating; 2: random.
  task automatic do_cmd(input bit op, input int mode, output ch_q got, output int holdbad,
                        output int cycles, output bit tmo);
    logic [7:0] prev;
    bit stalled;
    int k;
    got = {}; holdbad = 0; cycles = 0; tmo = 1'b0; stalled = 1'b0; prev = 8'h00; k = 0;
    cmd_valid = 1'b1; cmd_op = op;
    #1;
    while (!cmd_ready) begin
      @(negedge clk); cycles++;
      if (cycles > 100) begin tmo = 1'b1; cmd_valid = 1'b0; return; end
    end
    @(negedge clk);
    cmd_valid = 1'b0; cycles = 0;
    while (out_valid) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (k % 3 == 0);
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
      k++;
      if (stalled && out_char !== prev) holdbad++;
      if (out_ready) got.push_back(out_char);
      stalled = !out_ready;
      prev = out_char;
      @(negedge clk); cycles++;
      if (cycles > 200) begin tmo = 1'b1; break; end
    end
    out_ready = 1'b0;
    model_cmd(op);
  endtask

  task automatic test_reset;
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, out_char, depth, err, balanced, cmd_ready} !== {1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_async: got v=%b c=%h d=%0d e=%b b=%b r=%b want v=0 c=00 d=0 e=0 b=1 r=1",
               out_valid, out_char, depth, err, balanced, cmd_ready);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, depth, cmd_ready} !== {1'b0, 3'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_held: got v=%b d=%0d r=%b want v=0 d=0 r=1", out_valid, depth, cmd_ready);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, out_char, depth} !== {1'b1, 8'h62, 3'd1}) begin
      n_bad++;
      $display("FAIL first_cmd: got v=%b c=%h d=%0d want v=1 c=62 d=1", out_valid, out_char, depth);
    end
    cmd_valid = 1'b0; out_ready = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({out_valid, cmd_ready} !== 2'b01) begin
      n_bad++;
      $display("FAIL begin_len: got v=%b r=%b want v=0 r=1 after 6 chars", out_valid, cmd_ready);
    end
    out_ready = 1'b0;
    m_depth = 1; m_err = 1'b0;
  endtask

  task automatic test_basic;
    ch_q g1, g2; int hb, c1, c2; bit t1, t2; int d1;
    apply_reset();
    do_cmd(1'b0, 0, g1, hb, c1, t1);
    d1 = int'(depth);
    do_cmd(1'b1, 0, g2, hb, c2, t2);
    n_cmp++;
    if (t1 || t2 || hexs({g1, g2}) != hexw("begin end ")) begin
      n_bad++;
      $display("FAIL basic_chars: got %s want %s", hexs({g1, g2}), hexw("begin end "));
    end
    n_cmp++;
    if (c1 != 6 || c2 != 4) begin
      n_bad++;
      $display("FAIL basic_cycles: got %0d,%0d want 6,4", c1, c2);
    end
    n_cmp++;
    if (d1 != 1 || depth !== 3'd0 || balanced !== 1'b1 || cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_depth: got d1=%0d d=%0d b=%b r=%b want 1,0,1,1", d1, depth, balanced, cmd_ready);
    end
  endtask

  task automatic test_underflow;
    ch_q g; int hb, c; bit t;
    apply_reset();
    do_cmd(1'b1, 0, g, hb, c, t);
    n_cmp++;
    if (t || hexs(g) != hexw("end ")) begin
      n_bad++;
      $display("FAIL under_chars: got %s want %s", hexs(g), hexw("end "));
    end
    n_cmp++;
    if ({err, depth, balanced} !== {1'b1, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL under_flags: got e=%b d=%0d b=%b want e=1 d=0 b=0", err, depth, balanced);
    end
    do_cmd(1'b0, 0, g, hb, c, t);
    do_cmd(1'b1, 0, g, hb, c, t);
    n_cmp++;
    if ({err, depth, balanced} !== {1'b1, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL err_sticky: got e=%b d=%0d b=%b want e=1 d=0 b=0", err, depth, balanced);
    end
  endtask

  task automatic test_stall;
    ch_q g; int hb, c; bit t;
    apply_reset();
    do_cmd(1'b0, 1, g, hb, c, t);
    n_cmp++;
    if (t || hexs(g) != hexw("begin ")) begin
      n_bad++;
      $display("FAIL stall_chars: got %s want %s", hexs(g), hexw("begin "));
    end
    n_cmp++;
    if (hb != 0) begin
      n_bad++;
      $display("FAIL stall_hold: got %0d changes during stall want 0", hb);
    end
  endtask

  task automatic test_reset_mid;
    ch_q g; int hb, c; bit t;
    apply_reset();
    cmd_valid = 1'b1; cmd_op = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, out_char, depth, cmd_ready, balanced} !== {1'b0, 8'h00, 3'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid: got v=%b c=%h d=%0d r=%b b=%b want v=0 c=00 d=0 r=1 b=1",
               out_valid, out_char, depth, cmd_ready, balanced);
    end
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0; m_depth = 0; m_err = 1'b0;
    do_cmd(1'b0, 0, g, hb, c, t);
    n_cmp++;
    if (t || hexs(g) != hexw("begin ")) begin
      n_bad++;
      $display("FAIL reset_mid_next: got %s want %s", hexs(g), hexw("begin "));
    end
  endtask

  task automatic test_saturate;
    ch_q g; int hb, c; bit t;
    apply_reset();
    for (int i = 0; i < DMAX; i++) do_cmd(1'b0, 0, g, hb, c, t);
    n_cmp++;
    if ({depth, err} !== {DW'(DMAX), 1'b0}) begin
      n_bad++;
      $display("FAIL sat_fill: got d=%0d e=%b want d=%0d e=0", depth, err, DMAX);
    end
    do_cmd(1'b0, 0, g, hb, c, t);
    n_cmp++;
    if (t || hexs(g) != hexw("begin ") || {depth, err, balanced} !== {DW'(DMAX), 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL sat_over: got %s d=%0d e=%b want %s d=%0d e=1", hexs(g), depth, err, hexw("begin "), DMAX);
    end
  endtask

  task automatic test_random;
    ch_q g; int hb, c; bit t, op;
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      op = ($urandom_range(99) < 60) ? 1'b0 : 1'b1;
      do_cmd(op, 2, g, hb, c, t);
      n_cmp++;
      if (t || hb != 0 || hexs(g) != hexw(word_of(op))) begin
        n_bad++;
        $display("FAIL rand_chars[%0d]: got %s hold=%0d want %s", i, hexs(g), hb, hexw(word_of(op)));
      end
      n_cmp++;
      if (int'(depth) != m_depth || err !== m_err || balanced !== (m_depth == 0 && !m_err)) begin
        n_bad++;
        $display("FAIL rand_state[%0d]: got d=%0d e=%b b=%b want d=%0d e=%b", i, depth, err, balanced, m_depth, m_err);
      end
    end
  endtask

`ifdef BLOCK_EMITTER_AUTO_CLOSE_EN
  task automatic test_flush;
    ch_q g; int hb, c; bit t;
    apply_reset();
    flush = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_zero_ready: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, depth} !== {1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL flush_zero: got v=%b d=%0d want v=0 d=0", out_valid, depth);
    end
    flush = 1'b0;
    repeat (3) do_cmd(1'b0, 0, g, hb, c, t);
    g = {}; c = 0;
    flush = 1'b1; cmd_valid = 1'b1; cmd_op = 1'b0; out_ready = 1'b1;
    #1;
    while (!cmd_ready && c < 100) begin
      if (out_valid) g.push_back(out_char);
      @(negedge clk); c++;
    end
    cmd_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (c >= 100 || hexs(g) != hexw("end end end ")) begin
      n_bad++;
      $display("FAIL flush_chars: got %s want %s", hexs(g), hexw("end end end "));
    end
    n_cmp++;
    if ({depth, err, balanced} !== {3'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL flush_state: got d=%0d e=%b b=%b want d=0 e=0 b=1", depth, err, balanced);
    end
    m_depth = 0;
  endtask
`else
  task automatic test_flush;
    ch_q g; int hb, c; bit t;
    apply_reset();
    do_cmd(1'b0, 0, g, hb, c, t);
    flush = 1'b1;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_ignored_ready: got %b want 1", cmd_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, depth} !== {1'b0, 3'd1}) begin
      n_bad++;
      $display("FAIL flush_ignored: got v=%b d=%0d want v=0 d=1", out_valid, depth);
    end
    flush = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; flush = 1'b0; out_ready = 1'b0;
    m_depth = 0; m_err = 1'b0;
    test_reset();
    test_basic();
    test_underflow();
    test_stall();
    test_reset_mid();
    test_saturate();
    test_random();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
